hex_display_arbiter: RTL and testbench

//  Shares one signed-digit seven-segment display (value digit plus sign digit) among NREQ

---
 rtl/hex_display_arbiter.sv | 151 +++++++++++++++
 tb/tb_hex_display_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one signed-digit seven-segment display among NREQ requesters.
// Define HEX_ARB_BLINK_EN to blink the display while an overflowed value is shown.
module hex_display_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned HOLD_CYCLES  = 50000000,
    parameter int unsigned GAP_CYCLES   = 5000000,
    parameter int unsigned BLINK_CYCLES = 12500000,
    parameter int unsigned CW           = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] val,
    input  logic [NREQ-1:0]   ovf,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [3:0]        num,
    output logic              sign,
    output logic              of,
    output logic              off,
    output logic              dec,
    output logic              busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    // Elaboration-time guard: the shared counter width must cover every configured period.
    if ((((HOLD_CYCLES - 1) >> CW) != 0) || (((GAP_CYCLES - 1) >> CW) != 0) ||
        (((BLINK_CYCLES - 1) >> CW) != 0)) begin : g_cw_too_small
        $error("CW too narrow for the configured cycle counts");
    end

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     win;
    logic [IW-1:0]     cand;
    logic [NREQ-1:0]   win_oh;
    logic [3:0]        win_val;
    logic              win_ovf;
    logic              found;
    logic              grant;
    int unsigned       idx;

`ifdef HEX_ARB_BLINK_EN
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
    logic [CW-1:0]     bcnt;
`endif

    // First set request scanning ptr+1, ptr+2, ... with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx  = (32'(ptr) + k) % NREQ;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_oh  = NREQ'(1) << win;
        win_val = val[{win, 2'b00} +: 4];
        win_ovf = ovf[win];
    end

    assign grant = found && ((state == IDLE) || ((state == GAP) && (cnt == GAP_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= IW'(NREQ - 1);
            gnt   <= '0;
            ack   <= '0;
            num   <= '0;
            sign  <= 1'b0;
            of    <= 1'b0;
            off   <= 1'b1;
            dec   <= 1'b0;
            busy  <= 1'b0;
`ifdef HEX_ARB_BLINK_EN
            bcnt  <= '0;
`endif
        end else if (grant) begin
            state <= SHOW;
            cnt   <= '0;
            ptr   <= win;
            gnt   <= win_oh;
            ack   <= '0;
            num   <= win_val;
            sign  <= win_val[3];
            of    <= win_ovf;
            off   <= 1'b0;
            dec   <= win[0];
            busy  <= 1'b1;
`ifdef HEX_ARB_BLINK_EN
            bcnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    off <= 1'b1;
                end
                SHOW: begin
                    if (cnt == HOLD_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                        ack   <= gnt;
                        gnt   <= '0;
                        off   <= 1'b1;
                        dec   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
`ifdef HEX_ARB_BLINK_EN
                        if (of) begin
                            if (bcnt == BLINK_LAST) begin
                                off  <= ~off;
                                bcnt <= '0;
                            end else begin
                                bcnt <= bcnt + CW'(1);
                            end
                        end
`endif
                    end
                end
                GAP: begin
                    ack <= '0;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed vector table, corner sequences and a
// randomized run against a schedule-based reference model.
module tb_hex_display_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned BLINK = 1;
    localparam int unsigned CW    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] val = '0;
    logic [3:0]  ovf = '0;
    logic [3:0]  gnt, ack, num;
    logic        sign, of, off, dec, busy;

    hex_display_arbiter #(
        .NREQ(NREQ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BLINK_CYCLES(BLINK), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .val(val), .ovf(ovf),
        .gnt(gnt), .ack(ack), .num(num), .sign(sign), .of(of), .off(off), .dec(dec),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a grant is an event at an absolute edge; everything after it is a
    // function of the age (edges since the grant).
    bit         m_active;
    int         m_age;
    int         m_w;
    int         m_ptr;
    logic [3:0] m_num;
    logic       m_of;

    task automatic model_reset();
        m_active = 0;
        m_age    = 0;
        m_w      = 0;
        m_ptr    = NREQ - 1;
        m_num    = '0;
        m_of     = 1'b0;
    endtask

    task automatic model_edge();
        bit decide;
        bit hit;
        int idx;
        decide = !m_active || (m_age == int'(HOLD + GAP));
        hit = 0;
        if (decide) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!hit && req[idx]) begin
                    hit   = 1;
                    m_w   = idx;
                end
            end
        end
        if (hit) begin
            m_ptr    = m_w;
            m_active = 1;
            m_age    = 1;
            m_num    = val[4*m_w +: 4];
            m_of     = ovf[m_w];
        end else if (decide) begin
            m_active = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e_gnt, e_ack;
        logic       e_off, e_dec, showing;
        showing = m_active && (m_age <= int'(HOLD));
        e_gnt = showing ? 4'(1 << m_w) : 4'b0;
        e_ack = (m_active && m_age == int'(HOLD + 1)) ? 4'(1 << m_w) : 4'b0;
        e_dec = showing ? m_w[0] : 1'b0;
`ifdef HEX_ARB_BLINK_EN
        e_off = !showing ? 1'b1 : (m_of ? 1'(((m_age - 1) / BLINK) % 2) : 1'b0);
`else
        e_off = !showing;
`endif
        chk({tag, ".gnt"}, gnt, e_gnt);
        chk({tag, ".ack"}, ack, e_ack);
        chk({tag, ".num"}, num, m_num);
        chk({tag, ".sign"}, sign, m_num[3]);
        chk({tag, ".of"}, of, m_of);
        chk({tag, ".off"}, off, e_off);
        chk({tag, ".dec"}, dec, e_dec);
        chk({tag, ".busy"}, busy, m_active);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        val = '0;
        ovf = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] val;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [3:0]  num;
        logic        off;
        logic        dec;
        logic        busy;
    } vec_t;

    vec_t        tbl [14];
    int          order_q [$];
    int          decs_q [$];
    int          ack_q [$];
    int          exp_order [5];
    logic [3:0]  off_pat;
    logic [3:0]  prev_gnt;

    initial begin
        // Single-value show/ack/gap, then a held-data check with REQ dropped during SHOW.
        tbl[0]  = '{4'b0001, 16'h000d, 4'b0001, 4'b0000, 4'hd, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0001, 16'h000d, 4'b0001, 4'b0000, 4'hd, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4'b0000, 16'h000d, 4'b0001, 4'b0000, 4'hd, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 16'h000d, 4'b0001, 4'b0000, 4'hd, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'b0000, 16'h000d, 4'b0000, 4'b0001, 4'hd, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{4'b0000, 16'h000d, 4'b0000, 4'b0000, 4'hd, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{4'b0000, 16'h000d, 4'b0000, 4'b0000, 4'hd, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'b0100, 16'h0500, 4'b0100, 4'b0000, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'b0000, 16'hffff, 4'b0100, 4'b0000, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 16'hffff, 4'b0100, 4'b0000, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, 16'hffff, 4'b0100, 4'b0000, 4'h5, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{4'b0000, 16'hffff, 4'b0000, 4'b0100, 4'h5, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{4'b0000, 16'hffff, 4'b0000, 4'b0000, 4'h5, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{4'b0000, 16'hffff, 4'b0000, 4'b0000, 4'h5, 1'b1, 1'b0, 1'b0};
        exp_order = '{0, 1, 2, 3, 0};
`ifdef HEX_ARB_BLINK_EN
        off_pat = 4'b1010;
`else
        off_pat = 4'b0000;
`endif

        // Reset state held while idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step("idle");
            chk("idle.off", off, 1'b1);
            chk("idle.gnt", gnt, 4'b0);
            chk("idle.busy", busy, 1'b0);
        end

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            val = tbl[i].val;
            ovf = '0;
            @(negedge clk);
            chk($sformatf("tbl%0d.gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d.ack", i), ack, tbl[i].ack);
            chk($sformatf("tbl%0d.num", i), num, tbl[i].num);
            chk($sformatf("tbl%0d.sign", i), sign, tbl[i].num[3]);
            chk($sformatf("tbl%0d.off", i), off, tbl[i].off);
            chk($sformatf("tbl%0d.dec", i), dec, tbl[i].dec);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
        end

        // All requesters held: round-robin order, DEC tags, ACK spacing.
        do_reset();
        req = 4'b1111;
        val = 16'h8421;
        prev_gnt = '0;
        for (int c = 0; c < 30; c++) begin
            step("rr");
            if (gnt != 0 && prev_gnt == 0) begin
                order_q.push_back($clog2(gnt));
                decs_q.push_back(int'(dec));
            end
            if (ack != 0) ack_q.push_back(c);
            prev_gnt = gnt;
        end
        chk("rr.count", order_q.size(), 5);
        for (int i = 0; i < 5 && i < order_q.size(); i++) begin
            chk($sformatf("rr.order%0d", i), order_q[i], exp_order[i]);
            chk($sformatf("rr.dec%0d", i), decs_q[i], exp_order[i] % 2);
        end
        chk("rr.acks", ack_q.size(), 5);
        for (int i = 1; i < ack_q.size(); i++)
            chk($sformatf("rr.ackgap%0d", i), ack_q[i] - ack_q[i-1], HOLD + GAP);

        // Overflow shown steadily or blinking depending on the build.
        do_reset();
        req = 4'b0010;
        ovf = 4'b0010;
        val = 16'h00a0;
        step("ovf");
        req = '0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf.of%0d", i), of, 1'b1);
            chk($sformatf("ovf.off%0d", i), off, off_pat[i]);
            if (i < 3) step("ovf");
        end
        for (int i = 0; i < 4; i++) step("ovf.tail");

        // Asynchronous reset mid-SHOW, then a fresh grant to requester 1.
        do_reset();
        req = 4'b0001;
        ovf = 4'b0001;
        val = 16'h0007;
        step("arst");
        req = '0;
        step("arst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.gnt", gnt, 4'b0);
        chk("arst.ack", ack, 4'b0);
        chk("arst.num", num, 4'h0);
        chk("arst.sign", sign, 1'b0);
        chk("arst.of", of, 1'b0);
        chk("arst.off", off, 1'b1);
        chk("arst.dec", dec, 1'b0);
        chk("arst.busy", busy, 1'b0);
        @(negedge clk);
        chk("arst.noack", ack, 4'b0);
        rst_n = 1'b1;
        model_reset();
        req = 4'b0010;
        ovf = '0;
        val = 16'h00c0;
        step("arst.rel");
        chk("arst.regrant", gnt, 4'b0010);
        req = '0;
        for (int i = 0; i < 8; i++) step("arst.tail");

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            val = 16'($urandom);
            ovf = 4'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
